// File: rtl/cnn_pkg.sv
// Shared state encoding, default sizing and width helper for the CNN classification sequencer.
package cnn_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_HEIGHT = 28;
  localparam int DEF_WIDTH  = 28;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DRAIN,
    ST_ARGMAX,
    ST_DONE
  } cnn_state_e;

  // Address width for an index range of n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_argmax.sv
// Sequential signed max search over the DEPTH class accumulators, one class per cycle.
// A start pulse seeds the result with class 0; later classes win only when strictly greater.
module cnn_argmax
  import cnn_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CLS_W  = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [DEPTH*DATA_W-1:0] acc_data,
  output logic [CLS_W-1:0]        class_id,
  output logic [DATA_W-1:0]       max_val,
  output logic                    valid
);

  logic                     active_q, active_d;
  logic                     valid_q, valid_d;
  logic [CLS_W-1:0]         k_q, k_d;
  logic [CLS_W-1:0]         class_q, class_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [DATA_W-1:0] cand;
  logic [CLS_W-1:0]         sel;

  always_comb begin
    active_d = active_q;
    valid_d  = valid_q;
    k_d      = k_q;
    class_d  = class_q;
    max_d    = max_q;
    sel      = start ? '0 : k_q;
    cand     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel == CLS_W'(k)) cand = acc_data[k*DATA_W +: DATA_W];
    end

    if (start) begin
      class_d  = '0;
      max_d    = cand;
      k_d      = CLS_W'(1);
      active_d = (DEPTH > 1);
      valid_d  = (DEPTH == 1);
    end else if (active_q) begin
      if (cand > max_q) begin
        class_d = k_q;
        max_d   = cand;
      end
      k_d = k_q + CLS_W'(1);
      if (k_q == CLS_W'(DEPTH - 1)) begin
        active_d = 1'b0;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      k_q      <= '0;
      class_q  <= '0;
      max_q    <= '0;
    end else begin
      active_q <= active_d;
      valid_q  <= valid_d;
      k_q      <= k_d;
      class_q  <= class_d;
      max_q    <= max_d;
    end
  end

  assign class_id = class_q;
  assign max_val  = max_q;
  assign valid    = valid_q;

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Sequencer for a raster-scan CNN classifier: clears the class accumulators, streams every pixel
// address to the image/coefficient memories, waits out the read latency, then picks the winner.
module cnn_seq_ctrl
  import cnn_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int HEIGHT = DEF_HEIGHT,
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int RD_LAT = DEF_RD_LAT,
  localparam int ROW_W  = addr_w(HEIGHT),
  localparam int COL_W  = addr_w(WIDTH),
  localparam int CLS_W  = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stall,
  input  logic [DEPTH*DATA_W-1:0] acc_data,
  output logic [ROW_W-1:0]        row_addr,
  output logic [COL_W-1:0]        col_addr,
  output logic                    rd_en,
  output logic                    acc_clr,
  output logic                    acc_en,
  output logic                    busy,
  output logic                    done,
  output logic [CLS_W-1:0]        class_id,
  output logic [DATA_W-1:0]       max_val
);

  localparam int CNT_MAX = (RD_LAT > DEPTH) ? RD_LAT : DEPTH;
  localparam int CNT_W   = addr_w(CNT_MAX);

  cnn_state_e        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic              acc_clr_q, acc_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              argmax_start;
  logic              argmax_valid;

  // A read goes out in every unstalled SCAN cycle; the product returns RD_LAT cycles later.
  assign rd_en = (state_q == ST_SCAN) && !stall;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    pipe_d       = pipe_q << 1;
    pipe_d[0]    = rd_en;
    argmax_start = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_SCAN;
        row_d   = '0;
        col_d   = '0;
        cnt_d   = '0;
        pipe_d  = '0;
      end
      ST_SCAN: begin
        if (!stall) begin
          if (col_q == COL_W'(WIDTH - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(HEIGHT - 1)) begin
              row_d   = '0;
              cnt_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ST_ARGMAX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ARGMAX: begin
        argmax_start = (cnt_q == '0);
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    acc_clr_d = (state_d == ST_CLEAR);
    busy_d    = state_d inside {ST_CLEAR, ST_SCAN, ST_DRAIN, ST_ARGMAX};
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      pipe_q    <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      pipe_q    <= pipe_d;
      acc_clr_q <= acc_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  cnn_argmax #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_argmax (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (argmax_start),
    .acc_data (acc_data),
    .class_id (class_id),
    .max_val  (max_val),
    .valid    (argmax_valid)
  );

  assign row_addr = row_q;
  assign col_addr = col_q;
  assign acc_clr  = acc_clr_q;
  assign acc_en   = pipe_q[RD_LAT-1];
  assign busy     = busy_q;
  // The search result and the DONE state land on the same edge; both must agree to flag done.
  assign done     = done_q && argmax_valid;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Self-checking bench for cnn_seq_ctrl: table-driven argmax vectors, fixed and random stall
// patterns, reset mid-scan, and a second instance with a three-cycle memory read latency.
module tb_cnn_seq_ctrl;
  import cnn_pkg::*;

  localparam int DATA_W = 32;
  localparam int HEIGHT = 28;
  localparam int WIDTH  = 28;
  localparam int DEPTH  = 4;
  localparam int NPIX   = HEIGHT * WIDTH;

  typedef struct {
    logic [DEPTH*DATA_W-1:0] data;
    int                      mode;
    int                      exp_cls;
    int                      exp_max;
  } vec_t;

  logic                    clk     = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    start   = 1'b0;
  logic                    start3  = 1'b0;
  logic                    stall   = 1'b0;
  logic [DEPTH*DATA_W-1:0] acc_data = '0;

  logic [4:0]  row_addr, col_addr, row_addr3, col_addr3;
  logic        rd_en, acc_clr, acc_en, busy, done;
  logic        rd_en3, acc_clr3, acc_en3, busy3, done3;
  logic [1:0]  class_id, class_id3;
  logic [31:0] max_val, max_val3;

  int edge_cnt = 0;
  int n_checks = 0;
  int n_fail   = 0;

  int   rd_total = 0, acc_en_total = 0, clr_total = 0, lat_err = 0;
  int   rd3_total = 0, acc_en3_total = 0, clr3_total = 0, lat3_err = 0;
  int   order3_err = 0, idx3 = 0;
  logic       rd_hist1 = 1'b0;
  logic [2:0] rd_hist3 = 3'b000;

  cnn_seq_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stall    (stall),
    .acc_data (acc_data),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .rd_en    (rd_en),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .busy     (busy),
    .done     (done),
    .class_id (class_id),
    .max_val  (max_val)
  );

  cnn_seq_ctrl #(.RD_LAT(3)) dut3 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start3),
    .stall    (1'b0),
    .acc_data (acc_data),
    .row_addr (row_addr3),
    .col_addr (col_addr3),
    .rd_en    (rd_en3),
    .acc_clr  (acc_clr3),
    .acc_en   (acc_en3),
    .busy     (busy3),
    .done     (done3),
    .class_id (class_id3),
    .max_val  (max_val3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // acc_en must repeat rd_en one cycle later; reads, accumulates and clears are tallied.
  always @(negedge clk) begin
    if (!reset_n) begin
      rd_hist1 <= 1'b0;
    end else begin
      if (acc_en !== rd_hist1) lat_err <= lat_err + 1;
      rd_hist1 <= rd_en;
      if (rd_en === 1'b1) rd_total <= rd_total + 1;
      if (acc_en === 1'b1) acc_en_total <= acc_en_total + 1;
      if (acc_clr === 1'b1) clr_total <= clr_total + 1;
    end
  end

  // Same for the three-cycle-latency instance, plus its raster order.
  always @(negedge clk) begin
    if (!reset_n) begin
      rd_hist3 <= 3'b000;
      idx3     <= 0;
    end else begin
      if (acc_en3 !== rd_hist3[2]) lat3_err <= lat3_err + 1;
      rd_hist3 <= {rd_hist3[1:0], rd_en3};
      if (acc_en3 === 1'b1) acc_en3_total <= acc_en3_total + 1;
      if (acc_clr3 === 1'b1) begin
        clr3_total <= clr3_total + 1;
        idx3       <= 0;
      end else if (rd_en3 === 1'b1) begin
        rd3_total <= rd3_total + 1;
        if (row_addr3 !== 5'(idx3 / WIDTH) || col_addr3 !== 5'(idx3 % WIDTH))
          order3_err <= order3_err + 1;
        idx3 <= (idx3 + 1) % NPIX;
      end
    end
  end

  function automatic logic [DEPTH*DATA_W-1:0] pack4(input int a0, input int a1,
                                                    input int a2, input int a3);
    return {a3, a2, a1, a0};
  endfunction

  // Winner = largest signed value; among equal maxima the lowest index.
  function automatic void refArgmax(input logic [DEPTH*DATA_W-1:0] d, output int cls,
                                    output int mx);
    int v [DEPTH];
    for (int k = 0; k < DEPTH; k++) v[k] = $signed(d[k*DATA_W +: DATA_W]);
    mx = v[0];
    foreach (v[k]) if (v[k] > mx) mx = v[k];
    cls = -1;
    for (int k = DEPTH - 1; k >= 0; k--) if (v[k] == mx) cls = k;
  endfunction

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full pass on the RD_LAT=1 instance. mode 0: no stall, 1: ten stalls at read 100,
  // 2: random stalls everywhere, 3: extra start pulse during SCAN.
  task automatic applyStimulus(input string tag, input logic [DEPTH*DATA_W-1:0] data,
                               input int mode, input int exp_cls, input int exp_max);
    int   reads, s_cnt, held, scan_err, st_edge, done_edge, rd0, clr0, ae0;
    logic st;
    acc_data = data;
    rd0  = rd_total;
    clr0 = clr_total;
    ae0  = acc_en_total;
    @(posedge clk); #1;
    start   = 1'b1;
    st_edge = edge_cnt + 1;
    @(posedge clk); #1;
    start = 1'b0;
    stall = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    scan_err = 0;
    @(negedge clk);
    if (acc_clr !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rd_en !== 1'b0) scan_err++;
    @(posedge clk); #1;
    reads = 0;
    s_cnt = 0;
    held  = 0;
    while (reads < NPIX) begin
      case (mode)
        1:       st = (reads == 100 && held < 10);
        2:       st = ($urandom_range(0, 3) == 0);
        default: st = 1'b0;
      endcase
      if (st) held++;
      stall = st;
      start = (mode == 3 && reads == 50);
      @(negedge clk);
      if (rd_en !== !st || busy !== 1'b1 || acc_clr !== 1'b0 || done !== 1'b0 ||
          row_addr !== 5'(reads / WIDTH) || col_addr !== 5'(reads % WIDTH))
        scan_err++;
      if (st) s_cnt++;
      else reads++;
      @(posedge clk); #1;
    end
    start     = 1'b0;
    done_edge = -1;
    for (int i = 0; i < 40 && done_edge < 0; i++) begin
      if (mode == 2) stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done === 1'b1) done_edge = edge_cnt;
      else if (busy !== 1'b1 || rd_en !== 1'b0) scan_err++;
    end
    stall = 1'b0;
    checkOutput($sformatf("%s scan", tag), scan_err, 0);
    checkOutput($sformatf("%s reads", tag), rd_total - rd0, NPIX);
    checkOutput($sformatf("%s acc_en pulses", tag), acc_en_total - ae0, NPIX);
    checkOutput($sformatf("%s acc_clr cycles", tag), clr_total - clr0, 1);
    checkOutput($sformatf("%s done edge", tag), done_edge - st_edge, 1 + NPIX + 1 + DEPTH + s_cnt);
    checkOutput($sformatf("%s busy", tag), busy, 0);
    checkOutput($sformatf("%s class_id", tag), class_id, exp_cls);
    checkOutput($sformatf("%s max_val", tag), $signed(max_val), exp_max);
    acc_data = ~data;
    repeat (3) @(negedge clk);
    checkOutput($sformatf("%s class_id hold", tag), class_id, exp_cls);
    checkOutput($sformatf("%s max_val hold", tag), $signed(max_val), exp_max);
    checkOutput($sformatf("%s done hold", tag), done, 1);
  endtask

  // Reset asserted while the scan sits at (10,5); no done may follow.
  task automatic resetMidScan();
    int err;
    acc_data = pack4(1, 2, 3, 4);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    repeat (10 * WIDTH + 5) @(posedge clk);
    #1;
    checkOutput("mid-scan row", row_addr, 10);
    checkOutput("mid-scan col", col_addr, 5);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset row", row_addr, 0);
    checkOutput("async reset col", col_addr, 0);
    checkOutput("async reset ctl", {busy, done, rd_en, acc_en, acc_clr}, 0);
    checkOutput("async reset class_id", class_id, 0);
    checkOutput("async reset max_val", max_val, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    err = 0;
    repeat (900) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) err++;
    end
    checkOutput("no pass after reset", err, 0);
  endtask

  task automatic runLatencyPass(input logic [DEPTH*DATA_W-1:0] data);
    int rd0, ae0, clr0, st_edge, done_edge, cls, mx;
    acc_data = data;
    refArgmax(data, cls, mx);
    rd0  = rd3_total;
    ae0  = acc_en3_total;
    clr0 = clr3_total;
    @(posedge clk); #1;
    start3  = 1'b1;
    st_edge = edge_cnt + 1;
    @(posedge clk); #1;
    start3 = 1'b0;
    done_edge = -1;
    for (int i = 0; i < NPIX + 100 && done_edge < 0; i++) begin
      @(negedge clk);
      if (done3 === 1'b1) done_edge = edge_cnt;
    end
    checkOutput("lat3 reads", rd3_total - rd0, NPIX);
    checkOutput("lat3 acc_en pulses", acc_en3_total - ae0, NPIX);
    checkOutput("lat3 acc_clr cycles", clr3_total - clr0, 1);
    checkOutput("lat3 done edge", done_edge - st_edge, 1 + NPIX + 3 + DEPTH);
    checkOutput("lat3 busy", busy3, 0);
    checkOutput("lat3 class_id", class_id3, cls);
    checkOutput("lat3 max_val", $signed(max_val3), mx);
  endtask

  initial begin
    vec_t vecs [6];
    int   cls, mx, err;
    logic [DEPTH*DATA_W-1:0] d;

    vecs[0] = '{pack4(7, 100, 100, -5), 0, 1, 100};
    vecs[1] = '{pack4(-4, -3, -2, -1), 1, 3, -1};
    vecs[2] = '{pack4(5, 5, 5, 5), 0, 0, 5};
    vecs[3] = '{pack4(int'(32'h8000_0000), 0, -1, 32'sh7FFF_FFFF), 2, 3, 32'sh7FFF_FFFF};
    vecs[4] = '{pack4(3, 9, -9, 9), 3, 1, 9};
    vecs[5] = '{pack4(-7, -8, -9, -10), 2, 0, -7};

    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset row", row_addr, 0);
    checkOutput("reset col", col_addr, 0);
    checkOutput("reset rd_en", rd_en, 0);
    checkOutput("reset acc_clr", acc_clr, 0);
    checkOutput("reset acc_en", acc_en, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset class_id", class_id, 0);
    checkOutput("reset max_val", max_val, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    err = 0;
    for (int i = 0; i < 6; i++) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) err++;
    end
    stall = 1'b0;
    checkOutput("idle without start", err, 0);

    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].mode, vecs[i].exp_cls,
                    vecs[i].exp_max);

    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0)
        d = {$urandom, $urandom, $urandom, $urandom};
      else
        d = pack4(int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2,
                  int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2);
      refArgmax(d, cls, mx);
      applyStimulus($sformatf("rand%0d", r), d, 2, cls, mx);
    end

    resetMidScan();
    applyStimulus("after reset", pack4(0, 0, 0, 1), 0, 3, 1);

    runLatencyPass(pack4(10, -20, 30, 30));

    checkOutput("acc_en latency 1", lat_err, 0);
    checkOutput("acc_en latency 3", lat3_err, 0);
    checkOutput("lat3 raster order", order3_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_seq_ctrl.md
CNN_SEQ_CTRL -- requirements
Module: cnn_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, accumulator width per class (signed).
REQ-002 SHALL have parameter HEIGHT, default 28, image rows.
REQ-003 SHALL have parameter WIDTH, default 28, image columns.
REQ-004 SHALL have parameter DEPTH, default 4, number of classes / coefficient memories.
REQ-005 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (>=1).
REQ-006 SHALL have port: clk  in  1  single clock, all logic on posedge.
REQ-007 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port: start  in  1  begin one classification pass.
REQ-009 SHALL have port: stall  in  1  memory not ready; suppress read issue.
REQ-010 SHALL have port: acc_data  in  DEPTH*DATA_W  accumulators; class k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port: row_addr  out  clog2(HEIGHT)  read row, shared by image and all coefficient memories.
REQ-012 SHALL have port: col_addr  out  clog2(WIDTH)  read column.
REQ-013 SHALL have port: rd_en  out  1  read issued this cycle.
REQ-014 SHALL have port: acc_clr  out  1  zero all accumulators.
REQ-015 SHALL have port: acc_en  out  1  accumulate returning product.
REQ-016 SHALL have port: busy  out  1  pass in progress.
REQ-017 SHALL have port: done  out  1  result valid, held high.
REQ-018 SHALL have port: class_id  out  clog2(DEPTH)  winning class.
REQ-019 SHALL have port: max_val  out  DATA_W  winning accumulator value.

Function
REQ-020 SHALL implement FSM IDLE, CLEAR, SCAN, DRAIN, ARGMAX, DONE.
REQ-021 SHALL go IDLE->CLEAR, and DONE->CLEAR, on start=1; start SHALL be ignored in all other states.
REQ-022 SHALL assert acc_clr for exactly the one CLEAR cycle, then enter SCAN with row_addr=0, col_addr=0.
REQ-023 SHALL in SCAN assert rd_en when stall=0 and advance raster order, col fastest: col wraps WIDTH-1->0 with row+1.
REQ-024 SHALL hold addresses and deassert rd_en in any SCAN cycle with stall=1.
REQ-025 SHALL leave SCAN after the read of (HEIGHT-1, WIDTH-1) issues; exactly HEIGHT*WIDTH reads per pass.
REQ-026 SHALL drive acc_en as rd_en delayed by exactly RD_LAT cycles via a shift register cleared in CLEAR.
REQ-027 SHALL stay in DRAIN RD_LAT cycles; stall SHALL have no effect outside SCAN.
REQ-028 SHALL in ARGMAX scan k=0..DEPTH-1, one class per cycle, using a signed compare.
REQ-029 SHALL seed max_val/class_id with class 0 at k=0; class k replaces them only if strictly greater, so ties keep the lowest index.
REQ-030 SHALL enter DONE after DEPTH ARGMAX cycles: done=1, busy=0, class_id/max_val stable until next start.
REQ-031 SHALL assert busy in CLEAR, SCAN, DRAIN, ARGMAX only.
REQ-032 SHALL raise done exactly 1+HEIGHT*WIDTH+RD_LAT+DEPTH+S clock edges after the edge sampling start, where S = stalled SCAN cycles (790 at defaults, S=0).
REQ-033 SHALL drop done in the cycle after start is sampled in DONE.

Reset
REQ-034 SHALL on reset_n=0, immediately and asynchronously, force state IDLE, addresses 0, acc_en pipeline 0.
REQ-035 SHALL on reset_n=0 force rd_en, acc_clr, acc_en, busy, done to 0, and class_id, max_val to 0.
REQ-036 SHALL on reset mid-pass abandon the pass with no done pulse, and require a fresh start.

Structure
REQ-037 SHALL take the state enum and default parameter constants from shared package cnn_pkg.
REQ-038 SHALL place the sequential max search in sub-module cnn_argmax (start, acc_data -> class_id, max_val, valid).

Verification
REQ-039 SHALL cover: defaults, stall=0, one start -> 784 rd_en in raster order, last (27,27); acc_clr 1 cycle; done at edge 790.
REQ-040 SHALL cover: stall=1 for 10 SCAN cycles -> addresses hold, still 784 reads, done at edge 800.
REQ-041 SHALL cover: acc_data slices k0..k3 = {7,100,100,-5} -> class_id=1, max_val=100.
REQ-042 SHALL cover: slices {-4,-3,-2,-1} -> class_id=3, max_val=-1.
REQ-043 SHALL cover: RD_LAT=3 -> acc_en equals rd_en delayed 3 cycles, 784 acc_en pulses.
REQ-044 SHALL cover: reset_n low at SCAN address (10,5), then start -> restart at (0,0); start during busy is ignored.
